// File: rtl/reg_file_wr_ctrl.sv
// Register file write-side controller: clears every register after reset, then
// arbitrates two valid/ready writeback sources (round-robin) onto one registered write port.
//
// state | meaning
// CLEAR | sweeping zeros into every register, readies held low
// RUN   | arbitrating sources A and B onto the write port
module reg_file_wr_ctrl #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 4,
  parameter bit ZERO_R0    = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_a_valid,
  output logic                  o_a_ready,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [REG_WIDTH-1:0]  i_a_data,
  input  logic                  i_b_valid,
  output logic                  o_b_ready,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [REG_WIDTH-1:0]  i_b_data,
  output logic [ADDR_WIDTH-1:0] o_reg_addr_w,
  output logic [REG_WIDTH-1:0]  o_reg_val_w,
  output logic                  o_write_en,
  output logic                  o_init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nxt;
  logic                    last_b, last_b_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [REG_WIDTH-1:0]    val_nxt;
  logic                    en_nxt;
  logic                    done_nxt;
  logic                    a_rdy, b_rdy;

  // last_b resets high so that A wins the first contention
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      last_b       <= 1'b1;
      o_reg_addr_w <= '0;
      o_reg_val_w  <= '0;
      o_write_en   <= 1'b0;
      o_init_done  <= 1'b0;
    end else begin
      state        <= state_nxt;
      clr_cnt      <= clr_cnt_nxt;
      last_b       <= last_b_nxt;
      o_reg_addr_w <= addr_nxt;
      o_reg_val_w  <= val_nxt;
      o_write_en   <= en_nxt;
      o_init_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    last_b_nxt  = last_b;
    addr_nxt    = o_reg_addr_w;
    val_nxt     = o_reg_val_w;
    en_nxt      = 1'b0;
    done_nxt    = o_init_done;
    a_rdy       = 1'b0;
    b_rdy       = 1'b0;

    case (state)
      CLEAR: begin
        en_nxt      = 1'b1;
        addr_nxt    = clr_cnt;
        val_nxt     = '0;
        clr_cnt_nxt = clr_cnt + 1'b1;
        // terminal compare ends the sweep; counter parks at zero in RUN
        if (clr_cnt == LAST_ADDR) begin
          state_nxt   = RUN;
          done_nxt    = 1'b1;
          clr_cnt_nxt = '0;
        end
      end

      RUN: begin
        a_rdy = i_a_valid && (!i_b_valid || last_b);
        b_rdy = i_b_valid && !a_rdy;
        if (a_rdy) begin
          addr_nxt   = i_a_addr;
          val_nxt    = i_a_data;
          en_nxt     = !(ZERO_R0 && (i_a_addr == '0));
          last_b_nxt = 1'b0;
        end else if (b_rdy) begin
          addr_nxt   = i_b_addr;
          val_nxt    = i_b_data;
          en_nxt     = !(ZERO_R0 && (i_b_addr == '0));
          last_b_nxt = 1'b1;
        end
      end

      default: state_nxt = CLEAR;
    endcase
  end

  assign o_a_ready = a_rdy;
  assign o_b_ready = b_rdy;

endmodule

// File: doc/reg_file_wr_ctrl.md
# reg_file_wr_ctrl

Write-side controller for the register file. It first clears every register to zero after reset. It then arbitrates between two writeback sources (port A and port B) with valid/ready handshakes and round-robin priority. It drives the register file's single registered write port (address, data, enable).

## Interface
- REG_WIDTH, 32, data width of each register and of each writeback source
- ADDR_WIDTH, 4, register address width; NUM_REGS = 2**ADDR_WIDTH
- ZERO_R0, 0, when 1, writes to address 0 are accepted but never issued to the register file

One clock; reset is asynchronous and active-low.
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_a_valid  input  1  source A has a write pending
- o_a_ready  output  1  source A write accepted this cycle
- i_a_addr  input  ADDR_WIDTH  source A destination register
- i_a_data  input  REG_WIDTH  source A write data
- i_b_valid  input  1  source B has a write pending
- o_b_ready  output  1  source B write accepted this cycle
- i_b_addr  input  ADDR_WIDTH  source B destination register
- i_b_data  input  REG_WIDTH  source B write data
- o_reg_addr_w  output  ADDR_WIDTH  register file write address (registered)
- o_reg_val_w  output  REG_WIDTH  register file write data (registered)
- o_write_en  output  1  register file write enable (registered)
- o_init_done  output  1  high once the clear sweep has completed

## Operation
- FSM states: CLEAR and RUN. Reset state is CLEAR with clear counter = 0.
- **Reset values:** o_write_en=0, o_reg_addr_w=0, o_reg_val_w=0, o_init_done=0, o_a_ready=0, o_b_ready=0. The last-grant pointer resets to B, so A wins the first contention.
- **CLEAR:**
  - Each edge loads o_write_en=1, o_reg_addr_w=counter, o_reg_val_w=0, then increments the counter.
  - On the edge that loads counter = NUM_REGS-1: move to RUN and set o_init_done=1. o_init_done stays high until reset.
  - Readies are held at 0 throughout CLEAR, so valids are ignored. ZERO_R0 does not suppress the clear write to address 0.
- **RUN arbitration (combinational readies):**
  - Only A valid: o_a_ready=1.
  - Only B valid: o_b_ready=1.
  - Both valid: grant the source that did not win the most recent grant.
  - Neither valid: both readies are 0.
  - Readies are never both 1. The pointer updates only on an accepted transfer.
- **Accepted transfer (valid & ready at an edge):**
  - That edge loads o_reg_addr_w and o_reg_val_w from the granted source.
  - o_write_en=1, except when ZERO_R0=1 and addr==0, where o_write_en=0 but the handshake still completes.
- **No transfer at an edge in RUN:** o_write_en=0. The address and data registers hold their previous values.
- Ready depends on valid. Valid must not depend on ready.
- A source with valid=1 and ready=0 must hold its address and data stable. Under contention it is granted no later than the next cycle in which it is valid.

## Timing
- Clear sweep: o_write_en is high for exactly NUM_REGS consecutive cycles, starting after the first rising edge following reset deassertion.
- o_init_done rises on the same edge that presents the final clear write (address NUM_REGS-1).
- Readies may assert in the cycle immediately after that edge. There is no idle gap between the clear writes and RUN writes.
- Write latency: a handshake at edge N produces o_write_en=1 from edge N to edge N+1. The register file commits the write at edge N+1.
- Throughput: one write per cycle, sustained. With both sources continuously valid, grants alternate A, B, A, B…
- Reset asserted mid-sweep or mid-transfer: all outputs take their reset values immediately (asynchronously). Any registered write not yet committed is dropped. The sweep restarts from address 0.
- Counter width is ADDR_WIDTH+1 or terminal-compare based. It must not wrap back into CLEAR.

## Test plan
- **Reset then idle (ADDR_WIDTH=4):** o_write_en high 16 cycles, addresses 0..15, data 0. o_init_done rises with address 15. Then o_write_en=0.
- **A-only stream:** A writes addr 3 = 0xDEADBEEF, then addr 7 = 0x12345678 back-to-back. Each write is seen on the port one edge later, with o_b_ready=0.
- **Contention:** both valid for 4 cycles (A addr 1/data 0x11, B addr 2/data 0x22). Grants are A, B, A, B with o_write_en high every cycle. The held source's readies stay 0 while waiting.
- **Valid during CLEAR:** A valid from reset. o_a_ready=0 for all 16 sweep cycles. The first A write appears the cycle after o_init_done.
- **ZERO_R0=1:** A writes addr 0 = 0xFFFFFFFF. o_a_ready=1 but o_write_en stays 0. A following write to addr 5 is issued normally.
- **Mid-sweep reset:** i_rst_n low at sweep address 9. Outputs are zero immediately. After release the sweep restarts at address 0 and runs a full 16 writes.
